// File: rtl/rank_order_filter.sv
// Rank-order filter: fully sorts one WIN x WIN window per cycle through an
// N-stage registered odd-even transposition network and selects one order statistic.
module rank_order_filter #(
  parameter int unsigned DW  = 8,
  parameter int unsigned WIN = 3,
  parameter int unsigned RW  = $clog2(WIN*WIN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIN*WIN*DW-1:0]   in_win,
  input  logic [RW-1:0]           in_rank,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIN*WIN*DW-1:0]   out_sorted,
  output logic [DW-1:0]           out_sel,
  output logic                    out_rank_err
);

  localparam int unsigned N  = WIN*WIN;
  localparam int unsigned VW = N*DW;

  logic              en;
  logic [VW-1:0]     src     [N];
  logic [VW-1:0]     cx      [N];
  logic [VW-1:0]     st_data [N];
  // Rank is only needed up to the stage feeding the final select register.
  logic [RW-1:0]     st_rank [N-1];
  logic [N-1:0]      st_err;
  logic [N-1:0]      st_valid;
  logic [RW-1:0]     rank_c;
  logic              err_c;
  logic [DW-1:0]     sel_c;
  logic [DW-1:0]     sel_q;

  // Single global advance: the whole pipe moves unless the output is held.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Out-of-range ranks clamp to the maximum and are flagged.
  always_comb begin
    err_c  = (in_rank >= RW'(N));
    rank_c = err_c ? RW'(N - 1) : in_rank;
  end

  assign src[0] = in_win;
  for (genvar s = 1; s < N; s++) begin : g_src
    assign src[s] = st_data[s-1];
  end

  // Stage s (0-based) exchanges pairs starting at index s%2; pairs are disjoint.
  always_comb begin
    for (int unsigned s = 0; s < N; s++) begin
      cx[s] = src[s];
      for (int unsigned k = s % 2; k + 1 < N; k += 2) begin
        if (src[s][k*DW +: DW] > src[s][(k+1)*DW +: DW]) begin
          cx[s][k*DW +: DW]     = src[s][(k+1)*DW +: DW];
          cx[s][(k+1)*DW +: DW] = src[s][k*DW +: DW];
        end
      end
    end
  end

  // Select from the last stage's next value so out_sel is a plain register.
  always_comb begin
    sel_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (st_rank[N-2] == RW'(k)) begin
        sel_c = cx[N-1][k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_err   <= '0;
      sel_q    <= '0;
      for (int unsigned s = 0; s < N; s++) begin
        st_data[s] <= '0;
      end
      for (int unsigned s = 0; s < N - 1; s++) begin
        st_rank[s] <= '0;
      end
    end else if (en) begin
      st_valid   <= {st_valid[N-2:0], in_valid};
      st_err     <= {st_err[N-2:0], err_c};
      st_rank[0] <= rank_c;
      sel_q      <= sel_c;
      for (int unsigned s = 0; s < N; s++) begin
        st_data[s] <= cx[s];
      end
      for (int unsigned s = 1; s < N - 1; s++) begin
        st_rank[s] <= st_rank[s-1];
      end
    end
  end

  assign out_valid    = st_valid[N-1];
  assign out_rank_err = st_err[N-1];
  assign out_sorted   = st_data[N-1];
  assign out_sel      = sel_q;

endmodule
